pulse_sched: RTL and testbench

//   Round-robin scheduler sharing one prescaled pulse timer among N requesters.

---
 rtl/pulse_sched_if.sv | 48 ++++
 rtl/pulse_sched.sv | 127 ++++++++++++
 tb/tb_pulse_sched.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pulse_sched_if.sv
// rtl/pulse_sched_if.sv - request/pulse bundle between control logic and pulse_sched
//
// Purpose: groups the per-requester request, duration and timing-output
//          signals of pulse_sched into one port.
// Parameters: N (requesters), DW (duration field width in ticks).
// Signals:
//   req       [N]     level request per requester, held until its done
//   dur       [N*DW]  per-requester duration in ticks, dur[i*DW +: DW]
//   pulse_out [N]     one-hot timed pulse to the granted requester
//   grant_id  [3]     index of the current or last granted requester
//   busy      [1]     timer owned (RUN or DONE)
//   done      [N]     one-cycle one-hot completion strobe
//   abort     [1]     only with PULSE_SCHED_ABORT_EN: cut the running pulse short
// Modports: master = control logic side, slave = scheduler side.
interface pulse_sched_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  logic [N-1:0]    req;
  logic [N*DW-1:0] dur;
  logic [N-1:0]    pulse_out;
  logic [2:0]      grant_id;
  logic            busy;
  logic [N-1:0]    done;
`ifdef PULSE_SCHED_ABORT_EN
  logic            abort;

  modport master (
    output req, dur, abort,
    input  pulse_out, grant_id, busy, done
  );

  modport slave (
    input  req, dur, abort,
    output pulse_out, grant_id, busy, done
  );
`else
  modport master (
    output req, dur,
    input  pulse_out, grant_id, busy, done
  );

  modport slave (
    input  req, dur,
    output pulse_out, grant_id, busy, done
  );
`endif
endinterface

// File: rtl/pulse_sched.sv
// rtl/pulse_sched.sv - round-robin scheduler sharing one prescaled pulse timer
//
// Purpose: N requesters each ask for a timed pulse of dur[i] ticks (one tick =
//          PRESCALE clk cycles). Requests are served one at a time in
//          round-robin order; each completion gives a one-cycle done strobe.
// Parameters: N (2..8), DW (duration width), PRESCALE (clk cycles per tick, >=1).
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high
//   bus    pulse_sched_if.slave: req/dur in; pulse_out/grant_id/busy/done out
// Configuration: PULSE_SCHED_ABORT_EN adds bus.abort, which ends a RUN early
//   (DONE at the next edge). Undefined: every RUN completes its full duration.
module pulse_sched #(
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter int PRESCALE = 250000
) (
  input  logic        clk,
  input  logic        reset,
  pulse_sched_if.slave bus
);

  localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [DW-1:0] remain_q, remain_d;
  logic [TW-1:0] tick_q, tick_d;

  logic [2:0]    sel_id;
  logic          sel_found;
  logic [DW-1:0] sel_dur;
  logic [N-1:0]  grant_oh;
  logic          abort_req;

`ifdef PULSE_SCHED_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Round-robin pick: search from grant_q+1 upward, wrapping; the last
  // candidate is grant_q itself so a lone requester can be re-served.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_id    = grant_q;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(grant_q) + k) % N;
      if (!sel_found && bus.req[idx]) begin
        sel_found = 1'b1;
        sel_id    = 3'(idx);
      end
    end
  end

  assign sel_dur = bus.dur[sel_id*DW +: DW];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    remain_d = remain_q;
    tick_d   = tick_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_d  = sel_id;
          // A zero duration still produces a one-tick pulse.
          remain_d = (sel_dur == '0) ? DW'(1) : sel_dur;
          tick_d   = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_req) begin
          tick_d  = '0;
          state_d = ST_DONE;
        end else if (tick_q == TW'(PRESCALE - 1)) begin
          // Tick wrap: one tick of the pulse has elapsed.
          tick_d   = '0;
          remain_d = remain_q - 1'b1;
          if (remain_q == DW'(1)) begin
            state_d = ST_DONE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= 3'(N - 1);
      remain_q <= '0;
      tick_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      remain_q <= remain_d;
      tick_q   <= tick_d;
    end
  end

  // Outputs decode straight from state flops so an asynchronous reset
  // clears pulse_out immediately.
  assign grant_oh      = {{(N-1){1'b0}}, 1'b1} << grant_q;
  assign bus.pulse_out = (state_q == ST_RUN)  ? grant_oh : '0;
  assign bus.done      = (state_q == ST_DONE) ? grant_oh : '0;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_pulse_sched.sv
// tb/tb_pulse_sched.sv - directed self-checking bench for pulse_sched
module tb_pulse_sched;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pulse_sched_if #(.N(4), .DW(8)) bus ();

  pulse_sched #(.N(4), .DW(8), .PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.dur = '0;
`ifdef PULSE_SCHED_ABORT_EN
    bus.abort = 1'b0;
`endif
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Called at a sample where the pulse is already seen high for 'start'
  // cycles; returns the total high width, capped at 200.
  task automatic wait_pulse_end(input int start, output int width);
    width = start;
    while (bus.pulse_out != '0 && width < 200) begin
      step();
      if (bus.pulse_out != '0) width++;
    end
  endtask

  task automatic test_reset();
    bus.req = '0;
    bus.dur = '0;
`ifdef PULSE_SCHED_ABORT_EN
    bus.abort = 1'b0;
`endif
    reset = 1'b1;
    #1;
    n_checks++; if (bus.pulse_out !== 4'b0000) begin n_fail++; $display("FAIL reset_pulse: got %b want 0000", bus.pulse_out); end
    n_checks++; if (bus.done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b want 0000", bus.done); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.grant_id !== 3'd3) begin n_fail++; $display("FAIL reset_grant: got %0d want 3", bus.grant_id); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    int w;
    bus.dur = {8'd0, 8'd0, 8'd0, 8'd3};
    bus.req = 4'b0001;
    step();
    n_checks++; if (bus.pulse_out !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", bus.pulse_out); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    n_checks++; if (bus.grant_id !== 3'd0) begin n_fail++; $display("FAIL single_grant_id: got %0d want 0", bus.grant_id); end
    wait_pulse_end(1, w);
    n_checks++; if (w != 12) begin n_fail++; $display("FAIL single_width: got %0d want 12", w); end
    n_checks++; if (bus.done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b want 0001", bus.done); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_done_busy: got %b want 1", bus.busy); end
    bus.req = 4'b0000;
    step();
    n_checks++; if (bus.done !== 4'b0000) begin n_fail++; $display("FAIL single_done_clear: got %b want 0000", bus.done); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int w;
    int g;
    logic [3:0] exp;
    do_reset();
    bus.dur = {8'd1, 8'd1, 8'd1, 8'd1};
    bus.req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      exp = 4'b0001 << order[i];
      n_checks++; if (bus.pulse_out !== exp) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, bus.pulse_out, exp); end
      wait_pulse_end(1, w);
      n_checks++; if (w != 4) begin n_fail++; $display("FAIL rr_width[%0d]: got %0d want 4", i, w); end
      n_checks++; if (bus.done !== exp) begin n_fail++; $display("FAIL rr_done[%0d]: got %b want %b", i, bus.done, exp); end
      if (i < 4) begin
        g = 1;
        step();
        while (bus.pulse_out == '0 && g < 20) begin
          g++;
          step();
        end
        n_checks++; if (g != 2) begin n_fail++; $display("FAIL rr_gap[%0d]: got %0d want 2", i, g); end
      end else begin
        bus.req = 4'b0000;
        step();
      end
    end
  endtask

  task automatic test_zero_dur();
    int w;
    bus.dur = {8'd0, 8'd0, 8'd0, 8'd0};
    bus.req = 4'b0100;
    step();
    n_checks++; if (bus.pulse_out !== 4'b0100) begin n_fail++; $display("FAIL zero_grant: got %b want 0100", bus.pulse_out); end
    wait_pulse_end(1, w);
    n_checks++; if (w != 4) begin n_fail++; $display("FAIL zero_width: got %0d want 4", w); end
    n_checks++; if (bus.done !== 4'b0100) begin n_fail++; $display("FAIL zero_done: got %b want 0100", bus.done); end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_dropped_req();
    int w;
    bus.dur = {8'd0, 8'd0, 8'd0, 8'd5};
    bus.req = 4'b0001;
    step();
    n_checks++; if (bus.pulse_out !== 4'b0001) begin n_fail++; $display("FAIL drop_grant: got %b want 0001", bus.pulse_out); end
    step();
    step();
    step();
    bus.req = 4'b0000;
    wait_pulse_end(4, w);
    n_checks++; if (w != 20) begin n_fail++; $display("FAIL drop_width: got %0d want 20", w); end
    n_checks++; if (bus.done !== 4'b0001) begin n_fail++; $display("FAIL drop_done: got %b want 0001", bus.done); end
    step();
  endtask

  task automatic test_reset_mid_run();
    bus.dur = {8'd0, 8'd0, 8'd5, 8'd0};
    bus.req = 4'b0010;
    step();
    n_checks++; if (bus.pulse_out !== 4'b0010) begin n_fail++; $display("FAIL rst_run_grant: got %b want 0010", bus.pulse_out); end
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    #1;
    n_checks++; if (bus.pulse_out !== 4'b0000) begin n_fail++; $display("FAIL rst_run_pulse: got %b want 0000", bus.pulse_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_run_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.grant_id !== 3'd3) begin n_fail++; $display("FAIL rst_run_grant_id: got %0d want 3", bus.grant_id); end
    step();
    n_checks++; if (bus.done !== 4'b0000) begin n_fail++; $display("FAIL rst_run_done: got %b want 0000", bus.done); end
    reset   = 1'b0;
    bus.req = 4'b0011;
    step();
    n_checks++; if (bus.grant_id !== 3'd0) begin n_fail++; $display("FAIL rst_run_prio: got %0d want 0", bus.grant_id); end
    n_checks++; if (bus.pulse_out !== 4'b0001) begin n_fail++; $display("FAIL rst_run_prio_pulse: got %b want 0001", bus.pulse_out); end
    do_reset();
  endtask

`ifdef PULSE_SCHED_ABORT_EN
  task automatic test_abort();
    int w;
    int g;
    do_reset();
    bus.dur = {8'd0, 8'd0, 8'd1, 8'd4};
    bus.req = 4'b0011;
    step();
    n_checks++; if (bus.pulse_out !== 4'b0001) begin n_fail++; $display("FAIL abort_grant: got %b want 0001", bus.pulse_out); end
    step();
    step();
    bus.abort = 1'b1;
    wait_pulse_end(3, w);
    bus.abort = 1'b0;
    bus.req   = 4'b0010;
    n_checks++; if (w != 3) begin n_fail++; $display("FAIL abort_width: got %0d want 3", w); end
    n_checks++; if (bus.done !== 4'b0001) begin n_fail++; $display("FAIL abort_done: got %b want 0001", bus.done); end
    g = 1;
    step();
    while (bus.pulse_out == '0 && g < 20) begin
      g++;
      step();
    end
    n_checks++; if (g != 2) begin n_fail++; $display("FAIL abort_gap: got %0d want 2", g); end
    n_checks++; if (bus.pulse_out !== 4'b0010) begin n_fail++; $display("FAIL abort_next: got %b want 0010", bus.pulse_out); end
    do_reset();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_dur();
    test_dropped_req();
    test_reset_mid_run();
`ifdef PULSE_SCHED_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
